// File: rtl/dtmr_link_pkg.sv
// dtmr_link_pkg: framing constants and the transmit state type for the DTMR
// command link. Shared by the transmitter (cmd_tx) and the far-end receiver
// so both agree on the frame layout.
//   Frame: start(0), 10 data bits LSB first {mode,dir,speed}, even parity, stop(1).
package dtmr_link_pkg;

  localparam int FRAME_DATA_BITS = 10;
  localparam int FRAME_BITS      = 13;

  localparam int SPEED_LSB = 0;
  localparam int DIR_LSB   = 4;
  localparam int MODE_LSB  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Parity bit that makes the total count of ones in data+parity even.
  function automatic logic even_parity(input logic [FRAME_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/cmd_tx_if.sv
// cmd_tx_if: host-side command handshake for cmd_tx.
//   speed[3:0], dir[3:0], mode[1:0] : command fields
//   cmd_valid                       : host has a command
//   cmd_ready                       : transmitter can accept a command
// master = host, slave = transmitter.
interface cmd_tx_if;

  logic [3:0] speed;
  logic [3:0] dir;
  logic [1:0] mode;
  logic       cmd_valid;
  logic       cmd_ready;

  modport master (
    output speed, dir, mode, cmd_valid,
    input  cmd_ready
  );

  modport slave (
    input  speed, dir, mode, cmd_valid,
    output cmd_ready
  );

endinterface

// File: rtl/cmd_tx_bit_timer.sv
// bit_timer: free-running 0..CLKS_PER_BIT-1 cycle counter that paces serial
// bits.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear, holds the count at 0
//   tick     : high on the last cycle of a bit (count == CLKS_PER_BIT-1)
module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cmd_tx.sv
// cmd_tx: serial command transmitter for the DTMR command link.
// Accepts {mode,dir,speed} over a valid/ready handshake and sends it as a
// 13-bit parity-protected UART-style frame on tx. While idle it re-sends the
// last command every REFRESH_CYCLES cycles (0 disables this).
//   clk, rst  : clock, asynchronous active-high reset
//   cmd       : host command handshake (cmd_tx_if.slave)
//   tx        : serial line, idles high, registered
//   busy      : a frame is in progress
//   refresh_o : the current frame is an automatic re-send
//   frame_cnt : frames completed, modulo 256
module cmd_tx
  import dtmr_link_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 16,
  parameter int REFRESH_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  cmd_tx_if.slave     cmd,
  output logic        tx,
  output logic        busy,
  output logic        refresh_o,
  output logic [7:0]  frame_cnt
);

  localparam int IDLE_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] REFRESH_LAST =
    IDLE_W'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
  localparam logic [3:0] LAST_DATA_IDX = 4'(FRAME_DATA_BITS - 1);

  tx_state_t                  state_q, state_d;
  logic [3:0]                 bit_idx_q, bit_idx_d;
  logic [FRAME_DATA_BITS-1:0] hold_q, hold_d;
  logic                       have_cmd_q, have_cmd_d;
  logic                       refresh_q, refresh_d;
  logic [IDLE_W-1:0]          idle_cnt_q, idle_cnt_d;
  logic [7:0]                 frame_cnt_q, frame_cnt_d;
  logic                       tx_q, tx_d;

  logic bit_tick;
  logic accept;
  logic refresh_go;

  // The timer is held at 0 in IDLE so the start bit gets a full bit time
  // counted from the accept edge.
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == IDLE),
    .tick (bit_tick)
  );

  assign cmd.cmd_ready = (state_q == IDLE);
  assign accept        = cmd.cmd_valid && (state_q == IDLE);
  // A host command arriving on the refresh cycle takes priority.
  assign refresh_go    = (REFRESH_CYCLES != 0) && (state_q == IDLE) && have_cmd_q &&
                         !cmd.cmd_valid && (idle_cnt_q == REFRESH_LAST);

  assign tx        = tx_q;
  assign busy      = (state_q != IDLE);
  assign refresh_o = refresh_q;
  assign frame_cnt = frame_cnt_q;

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    hold_d      = hold_q;
    have_cmd_d  = have_cmd_q;
    refresh_d   = refresh_q;
    frame_cnt_d = frame_cnt_q;
    idle_cnt_d  = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          hold_d[SPEED_LSB +: 4] = cmd.speed;
          hold_d[DIR_LSB   +: 4] = cmd.dir;
          hold_d[MODE_LSB  +: 2] = cmd.mode;
          have_cmd_d = 1'b1;
          refresh_d  = 1'b0;
          state_d    = START;
        end else if (refresh_go) begin
          refresh_d = 1'b1;
          state_d   = START;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx_q == LAST_DATA_IDX) state_d = PARITY;
          else                            bit_idx_d = bit_idx_q + 4'd1;
        end
      end
      PARITY: begin
        if (bit_tick) state_d = STOP;
      end
      STOP: begin
        if (bit_tick) begin
          state_d     = IDLE;
          frame_cnt_d = frame_cnt_q + 8'd1;
          refresh_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next state so each bit appears on the
    // same edge that enters it (start bit falls on the accept edge).
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = hold_d[bit_idx_d];
      PARITY:  tx_d = even_parity(hold_d);
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_idx_q   <= '0;
      hold_q      <= '0;
      have_cmd_q  <= 1'b0;
      refresh_q   <= 1'b0;
      idle_cnt_q  <= '0;
      frame_cnt_q <= '0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      hold_q      <= hold_d;
      have_cmd_q  <= have_cmd_d;
      refresh_q   <= refresh_d;
      idle_cnt_q  <= idle_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      tx_q        <= tx_d;
    end
  end

endmodule

// File: tb/tb_cmd_tx.sv
// tb_cmd_tx: directed-vector bench for cmd_tx with CLKS_PER_BIT=4,
// REFRESH_CYCLES=64. Inputs and samples both happen 1 time unit after the
// rising edge.
module tb_cmd_tx;

  localparam int CPB = 4;
  localparam int RC  = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx, busy, refresh_o;
  logic [7:0] frame_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  cmd_tx_if bus ();

  cmd_tx #(.CLKS_PER_BIT(CPB), .REFRESH_CYCLES(RC)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (bus.slave),
    .tx        (tx),
    .busy      (busy),
    .refresh_o (refresh_o),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit i of the result is the i-th bit on the line.
  function automatic logic [12:0] mk_frame(input logic [3:0] s, input logic [3:0] d,
                                           input logic [1:0] m);
    logic [9:0]  data;
    logic [12:0] f;
    data     = {m, d, s};
    f[0]     = 1'b0;
    f[10:1]  = data;
    f[11]    = ^data;
    f[12]    = 1'b1;
    return f;
  endfunction

  // Called 1 unit after the edge that starts the frame; returns in the
  // first IDLE cycle after the stop bit.
  task automatic check_frame(input logic [12:0] f, input string tag, input logic exp_ref);
    for (int b = 0; b < 13; b++) begin
      for (int c = 0; c < CPB; c++) begin
        chk($sformatf("%s_bit%0d_c%0d", tag, b, c), tx, f[b]);
        if (c == 0) chk($sformatf("%s_ref_b%0d", tag, b), refresh_o, exp_ref);
        tick();
      end
    end
    chk({tag, "_idle_tx"}, tx, 1'b1);
    chk({tag, "_idle_ready"}, bus.cmd_ready, 1'b1);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_idle_ref"}, refresh_o, 1'b0);
  endtask

  task automatic set_cmd(input logic [3:0] s, input logic [3:0] d, input logic [1:0] m);
    bus.speed = s;
    bus.dir   = d;
    bus.mode  = m;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] f;
    int          busy_seen;

    set_cmd(4'd0, 4'd0, 2'd0);
    bus.cmd_valid = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst_tx", tx, 1'b1);
    chk("rst_ready", bus.cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ref", refresh_o, 1'b0);
    chk("rst_fcnt", frame_cnt, 8'd0);
    rst = 1'b0;

    // No refresh before the first command
    busy_seen = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (busy || !tx) busy_seen++;
    end
    chk("no_refresh_pre", busy_seen, 0);

    // Single frame: 5,3,2 -> hand-computed line sequence
    set_cmd(4'd5, 4'd3, 2'd2);
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    chk("single_busy", busy, 1'b1);
    chk("single_ready", bus.cmd_ready, 1'b0);
    check_frame(13'b1_1100_0110_1010, "single", 1'b0);
    chk("single_fcnt", frame_cnt, 8'd1);

    // Refresh after 64 idle cycles re-sends the same frame
    for (int i = 0; i < RC - 1; i++) tick();
    chk("refresh_not_yet", busy, 1'b0);
    tick();
    chk("refresh_busy", busy, 1'b1);
    check_frame(13'b1_1100_0110_1010, "refresh", 1'b1);
    chk("refresh_fcnt", frame_cnt, 8'd2);

    // Collision: cmd_valid on the exact refresh cycle -> host command wins
    for (int i = 0; i < RC - 1; i++) tick();
    chk("coll_idle", busy, 1'b0);
    set_cmd(4'd9, 4'd12, 2'd1);
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    chk("coll_busy", busy, 1'b1);
    check_frame(mk_frame(4'd9, 4'd12, 2'd1), "coll", 1'b0);
    chk("coll_fcnt", frame_cnt, 8'd3);

    // Back-to-back: A accepted, inputs switch to B mid-frame, B follows
    // after exactly one idle-high cycle
    set_cmd(4'd15, 4'd0, 2'd3);
    bus.cmd_valid = 1'b1;
    tick();
    set_cmd(4'd2, 4'd10, 2'd0);
    check_frame(mk_frame(4'd15, 4'd0, 2'd3), "b2b_a", 1'b0);
    tick();
    bus.cmd_valid = 1'b0;
    chk("b2b_b_start", busy, 1'b1);
    check_frame(mk_frame(4'd2, 4'd10, 2'd0), "b2b_b", 1'b0);
    chk("b2b_fcnt", frame_cnt, 8'd5);

    // Wrap: 251 more back-to-back frames, 53 cycles each
    set_cmd(4'd1, 4'd2, 2'd3);
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 250 * 53; i++) tick();
    chk("wrap_255", frame_cnt, 8'd255);
    for (int i = 0; i < 53; i++) tick();
    bus.cmd_valid = 1'b0;
    chk("wrap_0", frame_cnt, 8'd0);
    chk("wrap_idle", busy, 1'b0);

    // Mid-frame reset during DATA
    tick();
    set_cmd(4'd6, 4'd9, 2'd2);
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    f = mk_frame(4'd6, 4'd9, 2'd2);
    chk("mid_data_bit0", tx, f[1]);
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_ready", bus.cmd_ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_fcnt", frame_cnt, 8'd0);
    chk("mid_rst_ref", refresh_o, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle_tx", tx, 1'b1);
    set_cmd(4'd5, 4'd3, 2'd2);
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check_frame(13'b1_1100_0110_1010, "post_rst", 1'b0);
    chk("post_rst_fcnt", frame_cnt, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
